// File: rtl/pong_frame_scheduler.sv
// ---------------------------------------------------------------------------
// pong_frame_scheduler
//
// Holds the Pong scene (ball position and the two paddle heights) and decides
// when a new scene becomes visible. The CPU writes a shadow copy through a
// valid/ready port and then requests a commit; the shadow set is copied into
// the active set only at the start of vertical blanking, so a frame never
// shows a half-updated scene. The active set drives a 2-stage per-pixel
// arbiter (ball > left paddle > right paddle > background) that produces the
// colour for the VGA driver from its hCntr/vCntr counters.
//
// Ports
//   pxlClk          pixel clock
//   reset           synchronous, active-high
//   hCntr, vCntr    driver horizontal / vertical counters (14 bit)
//   wr_valid        CPU write request
//   wr_ready        write accepted when wr_valid & wr_ready
//   wr_addr         0=ballX, 1=ballY, 2=padL_Y, 3=padR_Y, 4..7 ignored
//   wr_data         register value (14 bit)
//   commit_req      one-cycle pulse: publish shadow at next vblank start
//   commit_pending  commit armed but not yet applied
//   frame_done      one-cycle pulse, high on the first cycle of the new scene
//   rgb_input       12-bit pixel colour, lags the counters by 2 cycles
// ---------------------------------------------------------------------------
module pong_frame_scheduler #(
    parameter int unsigned FRAME_WIDTH  = 1280,
    parameter int unsigned FRAME_HEIGHT = 960,
    parameter int unsigned BALL_SIZE    = 16,
    parameter int unsigned PAD_W        = 16,
    parameter int unsigned PAD_H        = 128,
    parameter int unsigned PAD_L_X      = 32,
    parameter int unsigned PAD_R_X      = 1232,
    parameter logic [11:0] BALL_RGB     = 12'hFFF,
    parameter logic [11:0] PAD_RGB      = 12'h0F0,
    parameter logic [11:0] BG_RGB       = 12'h000
) (
    input  logic        pxlClk,
    input  logic        reset,
    input  logic [13:0] hCntr,
    input  logic [13:0] vCntr,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [2:0]  wr_addr,
    input  logic [13:0] wr_data,
    input  logic        commit_req,
    output logic        commit_pending,
    output logic        frame_done,
    output logic [11:0] rgb_input
);

    localparam logic [13:0] FRAME_W_C    = 14'(FRAME_WIDTH);
    localparam logic [13:0] FRAME_H_C    = 14'(FRAME_HEIGHT);
    localparam logic [14:0] BALL_SIZE_C  = 15'(BALL_SIZE);
    localparam logic [14:0] PAD_H_C      = 15'(PAD_H);
    localparam logic [14:0] PAD_L_X_C    = 15'(PAD_L_X);
    localparam logic [14:0] PAD_L_END_C  = 15'(PAD_L_X + PAD_W);
    localparam logic [14:0] PAD_R_X_C    = 15'(PAD_R_X);
    localparam logic [14:0] PAD_R_END_C  = 15'(PAD_R_X + PAD_W);

    // Element 0 is ballX, 1 ballY, 2 padL_Y, 3 padR_Y.
    localparam logic [3:0][13:0] REG_RESET_C = {14'd416, 14'd416, 14'd472, 14'd632};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_COMMIT  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic             wr_ready_r;
    logic             commit_pending_r;
    logic             frame_done_r;
    logic [3:0][13:0] shadow_r;
    logic [3:0][13:0] active_r;
    logic             vblank_start_s;
    logic             wr_accept_s;

    logic [14:0]      h_ext_s;
    logic [14:0]      v_ext_s;
    logic [14:0]      ball_x_s;
    logic [14:0]      ball_y_s;
    logic [14:0]      pad_l_y_s;
    logic [14:0]      pad_r_y_s;
    logic             ball_hit_s;
    logic             pad_l_hit_s;
    logic             pad_r_hit_s;
    logic             pix_active_s;
    logic             ball_hit_r;
    logic             pad_l_hit_r;
    logic             pad_r_hit_r;
    logic             pix_active_r;
    logic [11:0]      pix_colour_s;
    logic [11:0]      rgb_r;

    assign vblank_start_s = (vCntr == FRAME_H_C) && (hCntr == 14'd0);
    // wr_ready_r is high exactly in IDLE, so it doubles as the write gate.
    assign wr_accept_s    = wr_valid && wr_ready_r;

    // Next-state logic for the commit scheduler
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (commit_req) begin
                    state_next_s = ST_PENDING;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_PENDING: begin
                if (vblank_start_s) begin
                    state_next_s = ST_COMMIT;
                end else begin
                    state_next_s = ST_PENDING;
                end
            end
            ST_COMMIT: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register; status outputs are registered from the next state so
    // they line up with the state they describe
    always_ff @(posedge pxlClk) begin
        if (reset) begin
            state_r          <= ST_IDLE;
            wr_ready_r       <= 1'b1;
            commit_pending_r <= 1'b0;
            frame_done_r     <= 1'b0;
        end else begin
            state_r          <= state_next_s;
            wr_ready_r       <= (state_next_s == ST_IDLE);
            commit_pending_r <= (state_next_s == ST_PENDING);
            frame_done_r     <= (state_next_s == ST_COMMIT);
        end
    end

    // Shadow register set, written by accepted CPU writes to addresses 0..3
    always_ff @(posedge pxlClk) begin
        if (reset) begin
            shadow_r <= REG_RESET_C;
        end else if (wr_accept_s && !wr_addr[2]) begin
            shadow_r[wr_addr[1:0]] <= wr_data;
        end
    end

    // Active register set, loaded on the edge that enters COMMIT so the new
    // scene is in place on the cycle frame_done is high
    always_ff @(posedge pxlClk) begin
        if (reset) begin
            active_r <= REG_RESET_C;
        end else if (state_next_s == ST_COMMIT) begin
            active_r <= shadow_r;
        end
    end

    // Hit tests run at 15 bits so position + size can never wrap back to 0.
    assign h_ext_s   = {1'b0, hCntr};
    assign v_ext_s   = {1'b0, vCntr};
    assign ball_x_s  = {1'b0, active_r[0]};
    assign ball_y_s  = {1'b0, active_r[1]};
    assign pad_l_y_s = {1'b0, active_r[2]};
    assign pad_r_y_s = {1'b0, active_r[3]};

    assign ball_hit_s   = (h_ext_s >= ball_x_s) && (h_ext_s < (ball_x_s + BALL_SIZE_C)) &&
                          (v_ext_s >= ball_y_s) && (v_ext_s < (ball_y_s + BALL_SIZE_C));
    assign pad_l_hit_s  = (h_ext_s >= PAD_L_X_C) && (h_ext_s < PAD_L_END_C) &&
                          (v_ext_s >= pad_l_y_s) && (v_ext_s < (pad_l_y_s + PAD_H_C));
    assign pad_r_hit_s  = (h_ext_s >= PAD_R_X_C) && (h_ext_s < PAD_R_END_C) &&
                          (v_ext_s >= pad_r_y_s) && (v_ext_s < (pad_r_y_s + PAD_H_C));
    assign pix_active_s = (hCntr < FRAME_W_C) && (vCntr < FRAME_H_C);

    // Pixel stage 1: register hit flags and the visible-area flag
    always_ff @(posedge pxlClk) begin
        if (reset) begin
            ball_hit_r   <= 1'b0;
            pad_l_hit_r  <= 1'b0;
            pad_r_hit_r  <= 1'b0;
            pix_active_r <= 1'b0;
        end else begin
            ball_hit_r   <= ball_hit_s;
            pad_l_hit_r  <= pad_l_hit_s;
            pad_r_hit_r  <= pad_r_hit_s;
            pix_active_r <= pix_active_s;
        end
    end

    // Fixed-priority colour select; blanking is forced to black
    always_comb begin
        pix_colour_s = BG_RGB;
        if (!pix_active_r) begin
            pix_colour_s = 12'h000;
        end else if (ball_hit_r) begin
            pix_colour_s = BALL_RGB;
        end else if (pad_l_hit_r) begin
            pix_colour_s = PAD_RGB;
        end else if (pad_r_hit_r) begin
            pix_colour_s = PAD_RGB;
        end else begin
            pix_colour_s = BG_RGB;
        end
    end

    // Pixel stage 2: registered colour output
    always_ff @(posedge pxlClk) begin
        if (reset) begin
            rgb_r <= 12'h000;
        end else begin
            rgb_r <= pix_colour_s;
        end
    end

    assign wr_ready       = wr_ready_r;
    assign commit_pending = commit_pending_r;
    assign frame_done     = frame_done_r;
    assign rgb_input      = rgb_r;

endmodule

// File: tb/tb_pong_frame_scheduler.sv
// ---------------------------------------------------------------------------
// Bench for pong_frame_scheduler. Counters are driven directly by the bench.
// A behavioural scene model (shadow/active position arrays, a pending flag
// and a per-pixel colour function written from the geometric rules) tracks
// expected outputs cycle by cycle.
// ---------------------------------------------------------------------------
module tb_pong_frame_scheduler;

    logic        pxlClk = 1'b0;
    logic        reset;
    logic [13:0] hCntr;
    logic [13:0] vCntr;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_addr;
    logic [13:0] wr_data;
    logic        commit_req;
    logic        commit_pending;
    logic        frame_done;
    logic [11:0] rgb_input;

    int errors = 0;
    int checks = 0;

    // Scene model
    int          m_sh[4];
    int          m_act[4];
    logic        m_pending;
    logic        m_commit_cyc;
    logic [11:0] m_s1;
    logic [11:0] m_rgb;

    always #5 pxlClk = ~pxlClk;

    pong_frame_scheduler dut (
        .pxlClk         (pxlClk),
        .reset          (reset),
        .hCntr          (hCntr),
        .vCntr          (vCntr),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .commit_req     (commit_req),
        .commit_pending (commit_pending),
        .frame_done     (frame_done),
        .rgb_input      (rgb_input)
    );

    function automatic logic [11:0] colour_at(int h, int v, int bx, int by, int pl, int pr);
        if (h >= 1280 || v >= 960) return 12'h000;
        if (h >= bx && h < bx + 16 && v >= by && v < by + 16) return 12'hFFF;
        if (h >= 32 && h < 48 && v >= pl && v < pl + 128) return 12'h0F0;
        if (h >= 1232 && h < 1248 && v >= pr && v < pr + 128) return 12'h0F0;
        return 12'h000;
    endfunction

    task automatic model_reset();
        m_sh  = '{632, 472, 416, 416};
        m_act = '{632, 472, 416, 416};
        m_pending    = 1'b0;
        m_commit_cyc = 1'b0;
        m_s1  = 12'h000;
        m_rgb = 12'h000;
    endtask

    // Advance model by one edge using the inputs currently driven, then clock.
    task automatic step();
        logic [11:0] c;
        logic        accepted;
        logic        done_now;
        if (reset) begin
            model_reset();
        end else begin
            c = colour_at(int'(hCntr), int'(vCntr), m_act[0], m_act[1], m_act[2], m_act[3]);
            accepted = wr_valid && !m_pending && !m_commit_cyc;
            done_now = m_pending && (vCntr == 14'd960) && (hCntr == 14'd0);
            if (done_now) begin
                for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
                m_pending = 1'b0;
            end else if (commit_req && !m_pending && !m_commit_cyc) begin
                m_pending = 1'b1;
            end
            if (accepted && wr_addr < 3'd4) m_sh[int'(wr_addr)] = int'(wr_data);
            m_commit_cyc = done_now;
            m_rgb = m_s1;
            m_s1  = c;
        end
        @(posedge pxlClk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_valid = 1'b0; wr_addr = 3'd0; wr_data = 14'd0; commit_req = 1'b0;
        hCntr = 14'd1300; vCntr = 14'd20;
    endtask

    task automatic write_reg(input int a, input int d);
        wr_valid = 1'b1; wr_addr = 3'(a); wr_data = 14'(d);
        step();
        wr_valid = 1'b0;
    endtask

    // Request a commit mid-frame, then present vblank start; reports frame_done.
    task automatic commit_now(output logic done_seen);
        hCntr = 14'd0; vCntr = 14'd10; commit_req = 1'b1;
        step();
        commit_req = 1'b0; vCntr = 14'd960;
        step();
        done_seen = frame_done;
        hCntr = 14'd1;
        step();
        idle_inputs();
    endtask

    // Hold one pixel for the full pipeline depth and return the colour.
    task automatic pix(input int h, input int v, output logic [11:0] got);
        hCntr = 14'(h); vCntr = 14'(v);
        step(); step();
        got = rgb_input;
        idle_inputs();
    endtask

    task automatic test_reset();
        logic [11:0] g;
        reset = 1'b1; idle_inputs();
        step(); step(); step();
        reset = 1'b0;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
        checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got=%b exp=0", commit_pending); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", frame_done); end
        checks++; if (rgb_input !== 12'h000) begin errors++; $display("FAIL reset_rgb got=%h exp=000", rgb_input); end
        pix(632, 472, g); checks++; if (g !== 12'hFFF) begin errors++; $display("FAIL reset_ball_tl got=%h exp=FFF", g); end
        pix(647, 487, g); checks++; if (g !== 12'hFFF) begin errors++; $display("FAIL reset_ball_br got=%h exp=FFF", g); end
        pix(648, 472, g); checks++; if (g !== 12'h000) begin errors++; $display("FAIL reset_ball_right got=%h exp=000", g); end
        pix(632, 471, g); checks++; if (g !== 12'h000) begin errors++; $display("FAIL reset_ball_above got=%h exp=000", g); end
    endtask

    task automatic test_write_commit();
        logic [11:0] g;
        write_reg(0, 100); write_reg(1, 200);
        hCntr = 14'd0; vCntr = 14'd10; commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        checks++; if (commit_pending !== 1'b1) begin errors++; $display("FAIL wc_pending got=%b exp=1", commit_pending); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL wc_ready_low got=%b exp=0", wr_ready); end
        pix(632, 472, g); checks++; if (g !== 12'hFFF) begin errors++; $display("FAIL wc_old_ball got=%h exp=FFF", g); end
        pix(100, 200, g); checks++; if (g !== 12'h000) begin errors++; $display("FAIL wc_new_early got=%h exp=000", g); end
        hCntr = 14'd0; vCntr = 14'd960;
        step();
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL wc_done got=%b exp=1", frame_done); end
        checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL wc_pending_clr got=%b exp=0", commit_pending); end
        hCntr = 14'd1;
        step();
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL wc_done_once got=%b exp=0", frame_done); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL wc_ready_back got=%b exp=1", wr_ready); end
        pix(100, 200, g); checks++; if (g !== 12'hFFF) begin errors++; $display("FAIL wc_new_ball got=%h exp=FFF", g); end
        pix(115, 215, g); checks++; if (g !== 12'hFFF) begin errors++; $display("FAIL wc_new_br got=%h exp=FFF", g); end
        pix(632, 472, g); checks++; if (g !== 12'h000) begin errors++; $display("FAIL wc_old_gone got=%h exp=000", g); end
        // Two-cycle lag: colour of h=100 appears two edges after it is driven
        hCntr = 14'd98; vCntr = 14'd200;
        step(); step();
        hCntr = 14'd100;
        step();
        checks++; if (rgb_input !== 12'h000) begin errors++; $display("FAIL lag_first got=%h exp=000", rgb_input); end
        hCntr = 14'd101;
        step();
        checks++; if (rgb_input !== 12'hFFF) begin errors++; $display("FAIL lag_second got=%h exp=FFF", rgb_input); end
        idle_inputs();
    endtask

    task automatic test_freeze();
        logic [11:0] g;
        logic d;
        hCntr = 14'd0; vCntr = 14'd10; commit_req = 1'b1;
        step();
        commit_req = 1'b0; wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 14'd5;
        for (int i = 0; i < 4; i++) begin
            hCntr = 14'(i + 1);
            step();
            checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL frz_ready got=%b exp=0 cyc=%0d", wr_ready, i); end
        end
        hCntr = 14'd0; vCntr = 14'd960;
        step();
        checks++; if (frame_done !== 1'b1 || wr_ready !== 1'b0) begin errors++; $display("FAIL frz_commit done=%b ready=%b exp=1,0", frame_done, wr_ready); end
        hCntr = 14'd1;
        step();
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL frz_ready_after got=%b exp=1", wr_ready); end
        step();
        idle_inputs();
        pix(100, 200, g); checks++; if (g !== 12'hFFF) begin errors++; $display("FAIL frz_active_kept got=%h exp=FFF", g); end
        pix(5, 200, g);   checks++; if (g !== 12'h000) begin errors++; $display("FAIL frz_not_active got=%h exp=000", g); end
        commit_now(d);
        checks++; if (d !== 1'b1) begin errors++; $display("FAIL frz_commit2 got=%b exp=1", d); end
        pix(5, 200, g);   checks++; if (g !== 12'hFFF) begin errors++; $display("FAIL frz_shadow_took got=%h exp=FFF", g); end
    endtask

    task automatic test_priority();
        logic [11:0] g;
        logic d;
        write_reg(0, 32); write_reg(1, 416);
        commit_now(d);
        pix(40, 420, g);   checks++; if (g !== 12'hFFF) begin errors++; $display("FAIL prio_ball got=%h exp=FFF", g); end
        pix(40, 500, g);   checks++; if (g !== 12'h0F0) begin errors++; $display("FAIL prio_padl got=%h exp=0F0", g); end
        pix(40, 544, g);   checks++; if (g !== 12'h000) begin errors++; $display("FAIL prio_padl_end got=%h exp=000", g); end
        pix(1240, 416, g); checks++; if (g !== 12'h0F0) begin errors++; $display("FAIL prio_padr got=%h exp=0F0", g); end
        pix(1248, 416, g); checks++; if (g !== 12'h000) begin errors++; $display("FAIL prio_padr_edge got=%h exp=000", g); end
    endtask

    task automatic test_edges();
        logic [11:0] g;
        logic d;
        write_reg(0, 1270); write_reg(1, 950); write_reg(3, 900);
        commit_now(d);
        pix(1275, 955, g); checks++; if (g !== 12'hFFF) begin errors++; $display("FAIL edge_ball got=%h exp=FFF", g); end
        pix(1279, 959, g); checks++; if (g !== 12'hFFF) begin errors++; $display("FAIL edge_ball_corner got=%h exp=FFF", g); end
        pix(1280, 955, g); checks++; if (g !== 12'h000) begin errors++; $display("FAIL edge_hblank got=%h exp=000", g); end
        pix(1279, 960, g); checks++; if (g !== 12'h000) begin errors++; $display("FAIL edge_vblank got=%h exp=000", g); end
        pix(1240, 959, g); checks++; if (g !== 12'h0F0) begin errors++; $display("FAIL edge_padr got=%h exp=0F0", g); end
        pix(1240, 960, g); checks++; if (g !== 12'h000) begin errors++; $display("FAIL edge_padr_clip got=%h exp=000", g); end
        pix(2, 3, g);      checks++; if (g !== 12'h000) begin errors++; $display("FAIL edge_nowrap_a got=%h exp=000", g); end
        // Ball near the 14-bit limit must not wrap onto column 0
        write_reg(0, 16380); write_reg(1, 0);
        commit_now(d);
        pix(4, 4, g);      checks++; if (g !== 12'h000) begin errors++; $display("FAIL edge_nowrap_b got=%h exp=000", g); end
        pix(0, 0, g);      checks++; if (g !== 12'h000) begin errors++; $display("FAIL edge_nowrap_c got=%h exp=000", g); end
    endtask

    task automatic test_vblank_req();
        hCntr = 14'd0; vCntr = 14'd960; commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        checks++; if (commit_pending !== 1'b1 || frame_done !== 1'b0) begin errors++; $display("FAIL vbreq_arm pend=%b done=%b exp=1,0", commit_pending, frame_done); end
        hCntr = 14'd1;
        step();
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL vbreq_no_same got=%b exp=0", frame_done); end
        hCntr = 14'd0;
        step();
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL vbreq_next got=%b exp=1", frame_done); end
        hCntr = 14'd1;
        step();
        idle_inputs();
    endtask

    task automatic test_reset_pending();
        logic [11:0] g;
        logic d;
        write_reg(0, 300);
        hCntr = 14'd0; vCntr = 14'd10; commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        checks++; if (commit_pending !== 1'b1) begin errors++; $display("FAIL rp_armed got=%b exp=1", commit_pending); end
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        checks++; if (commit_pending !== 1'b0 || wr_ready !== 1'b1) begin errors++; $display("FAIL rp_state pend=%b ready=%b exp=0,1", commit_pending, wr_ready); end
        hCntr = 14'd0; vCntr = 14'd960;
        step();
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rp_no_done got=%b exp=0", frame_done); end
        idle_inputs();
        pix(632, 472, g); checks++; if (g !== 12'hFFF) begin errors++; $display("FAIL rp_active_reset got=%h exp=FFF", g); end
        commit_now(d);
        checks++; if (d !== 1'b1) begin errors++; $display("FAIL rp_commit got=%b exp=1", d); end
        pix(300, 472, g); checks++; if (g !== 12'h000) begin errors++; $display("FAIL rp_shadow_reset got=%h exp=000", g); end
        pix(640, 480, g); checks++; if (g !== 12'hFFF) begin errors++; $display("FAIL rp_ball_home got=%h exp=FFF", g); end
    endtask

    task automatic test_random();
        int sel;
        int h;
        int v;
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 249) == 0);
            sel = $urandom_range(0, 15);
            if (sel == 0) begin
                h = 0; v = 960;
            end else if (sel < 6) begin
                h = m_act[0] + $urandom_range(0, 19) - 2;
                v = m_act[1] + $urandom_range(0, 19) - 2;
            end else if (sel < 10) begin
                h = ($urandom_range(0, 1) == 0) ? $urandom_range(28, 52) : $urandom_range(1228, 1252);
                v = m_act[2] + $urandom_range(0, 135) - 4;
            end else begin
                h = $urandom_range(0, 1400);
                v = $urandom_range(0, 1000);
            end
            hCntr = 14'(h); vCntr = 14'(v);
            wr_valid   = ($urandom_range(0, 2) == 0);
            wr_addr    = 3'($urandom_range(0, 7));
            wr_data    = ($urandom_range(0, 7) == 0) ? 14'($urandom_range(16370, 16383)) : 14'($urandom_range(0, 1300));
            commit_req = ($urandom_range(0, 9) == 0);
            step();
            checks++; if (wr_ready !== (!m_pending && !m_commit_cyc)) begin errors++; $display("FAIL rnd_ready n=%0d got=%b", n, wr_ready); end
            checks++; if (commit_pending !== m_pending) begin errors++; $display("FAIL rnd_pending n=%0d got=%b exp=%b", n, commit_pending, m_pending); end
            checks++; if (frame_done !== m_commit_cyc) begin errors++; $display("FAIL rnd_done n=%0d got=%b exp=%b", n, frame_done, m_commit_cyc); end
            checks++; if (rgb_input !== m_rgb) begin errors++; $display("FAIL rnd_rgb n=%0d got=%h exp=%h", n, rgb_input, m_rgb); end
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        model_reset();
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_write_commit();
        test_freeze();
        test_priority();
        test_edges();
        test_vblank_req();
        test_reset_pending();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
